read_burst_scheduler: RTL and testbench
=======================================

# read_burst_scheduler

Sequences the AXI read bursts of one frame, or one line, for the VDMA read channel. On `fsync` it issues normal bursts of `NOR_BURST_LEN` beats to the AXI read master. It issues each burst only when the downstream FIFO has room, and it follows each completed burst with a `burst_done` pulse. When the line-length status block reports `tail_status`, the scheduler issues a final burst of `tail_len` beats and signals `tail_done`. The block sits between the line-length status block and the AXI read master, and it closes the loop between the two.

## Interface
Parameters:
- `NOR_BURST_LEN`, 200: beats per normal burst; must match the status block.
- `LSIZE`, 9: width of burst-length fields.
- `ASIZE`, 32: byte address width.
- `AXI_DSIZE`, 256: AXI data width in bits; the byte step per beat is `AXI_DSIZE/8`.
- `SETTLE`, 4: wait cycles before sampling `tail_status` after `fsync` or a done pulse. Legal range is 1–15.

Ports:
- `clock` in 1: clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `enable` in 1: while low, `fsync` is ignored. A burst already in flight still completes.
- `fsync` in 1: frame/line start pulse, one cycle.
- `base_addr` in ASIZE: start byte address, latched on an accepted `fsync`.
- `tail_status` in 1: from the status block; high means the next burst is the tail.
- `tail_len` in LSIZE: tail burst length in beats; nonzero.
- `fifo_space` in 16: free entries in the downstream FIFO, in AXI words.
- `req_valid` out 1: burst request to the AXI read master.
- `req_ready` in 1: the master accepts the request.
- `req_addr` out ASIZE: burst start byte address.
- `req_len` out LSIZE: burst length in beats.
- `rd_done` in 1: one-cycle pulse when the last beat of the accepted burst is received.
- `burst_done` out 1: one-cycle pulse when a normal burst completes.
- `tail_done` out 1: one-cycle pulse when the tail burst completes.
- `busy` out 1: high from an accepted `fsync` until the return to IDLE.
- `burst_cnt` out 16: bursts completed in the current frame.

## Operation
- States:
  - IDLE: accepts `fsync` when `enable` is high.
  - SETTLE: counts `SETTLE` cycles.
  - DECIDE: samples `tail_status`.
    - Low: length is `NOR_BURST_LEN`, `is_tail`=0.
    - High: length is `tail_len`, `is_tail`=1.
  - WAIT_SPACE: waits for `fifo_space >= req_len`.
  - REQ: holds `req_valid` until `req_ready`.
  - WAIT_DONE: waits for `rd_done`.
  - DONE: pulses `burst_done` or `tail_done`.
- Transitions:
  - IDLE → SETTLE on `fsync`. `addr` and `burst_cnt` are set to `base_addr` and 0.
  - SETTLE → DECIDE → WAIT_SPACE → REQ → WAIT_DONE → DONE.
  - DONE → SETTLE if `is_tail`=0.
  - DONE → IDLE if `is_tail`=1.
- Address and count update in DONE: `addr += req_len * (AXI_DSIZE/8)`, computed modulo 2^ASIZE, and `burst_cnt` increments. The counter saturates at 16'hFFFF.
- `fsync` with `enable` high:
  - In SETTLE, DECIDE or WAIT_SPACE: restart, meaning reload `base_addr`, clear `burst_cnt`, and enter SETTLE.
  - In REQ or WAIT_DONE: set `restart_pend`. The burst completes, then DONE is skipped, with no done pulse and no counter update. The block enters SETTLE with `base_addr`.
  - In DONE: the pulse is still issued, then the block restarts.
- `rd_done` outside WAIT_DONE is ignored.
- `fsync` with `enable` low is ignored in every state.

## Timing
- All outputs are registered.
- Reset values: `req_valid`=0, `req_addr`=0, `req_len`=0, `burst_done`=0, `tail_done`=0, `busy`=0, `burst_cnt`=0. The state is IDLE and `restart_pend`=0.
- `fsync` in cycle t puts the block in SETTLE at t+1.
  - With unlimited FIFO space, `req_valid` first rises at t+SETTLE+3: t+SETTLE+1 is DECIDE, t+SETTLE+2 is WAIT_SPACE, and REQ is registered.
- `req_addr` and `req_len` are stable from the rise of `req_valid` until the handshake cycle. `req_valid` drops in the cycle after `req_valid & req_ready`.
- Only one burst is outstanding at any time.
- `rd_done` in cycle u gives a done pulse at u+1. The next DECIDE follows at u+1+SETTLE+1.
- `busy` falls in the cycle after `tail_done`.
- A synchronous reset in any state forces the reset values on the next edge. An in-flight `rd_done` is then dropped.

## Test plan
- Frame with `NOR_BURST_LEN`=16, `AXI_DSIZE`=256, `base_addr`=0x1000, status model raising `tail_status` after 2 bursts, `tail_len`=5 → requests (0x1000,16), (0x1200,16), (0x1400,5). Two `burst_done` pulses, one `tail_done`, `burst_cnt`=3, then IDLE.
- `req_ready` held low for 10 cycles → `req_valid` stays high, with `req_addr` and `req_len` unchanged. Exactly one handshake follows.
- `fifo_space`=10 with `req_len`=16 → no `req_valid`. Raising `fifo_space` to 16 → `req_valid` 1 cycle later.
- `fsync` during WAIT_DONE of the second burst → no pulse after its `rd_done`. The next request is at `base_addr` and `burst_cnt` returns to 0.
- `tail_status` high at the first DECIDE with `tail_len`=3 → a single request of 3 beats, then `tail_done`. No `burst_done` pulse occurs.
- Reset asserted in WAIT_DONE, with `rd_done` arriving afterwards → all outputs at their reset values and no done pulses. `fsync` with `enable`=0 → the block stays in IDLE.

Source files
------------

// File: rtl/read_burst_scheduler.sv
// Issues one AXI read burst at a time for a frame/line: normal bursts until the status block flags the tail, then one tail burst.
// All outputs registered; a burst waits for FIFO room and for req_ready, and only one burst is outstanding at any time.
module read_burst_scheduler #(
    parameter int NOR_BURST_LEN = 200,
    parameter int LSIZE         = 9,
    parameter int ASIZE         = 32,
    parameter int AXI_DSIZE     = 256,
    parameter int SETTLE        = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fsync,
    input  logic [ASIZE-1:0] base_addr,
    input  logic             tail_status,
    input  logic [LSIZE-1:0] tail_len,
    input  logic [15:0]      fifo_space,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [ASIZE-1:0] req_addr,
    output logic [LSIZE-1:0] req_len,
    input  logic             rd_done,
    output logic             burst_done,
    output logic             tail_done,
    output logic             busy,
    output logic [15:0]      burst_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_DECIDE, S_WAIT_SPACE, S_REQ, S_WAIT_DONE, S_DONE
    } state_t;

    localparam logic [ASIZE-1:0] BEAT_BYTES  = ASIZE'(AXI_DSIZE / 8);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [LSIZE-1:0] NOR_LEN     = LSIZE'(NOR_BURST_LEN);

    state_t           state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic [ASIZE-1:0] pend_addr_q, pend_addr_d;
    logic             pend_q, pend_d;
    logic             is_tail_q, is_tail_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [ASIZE-1:0] req_addr_q, req_addr_d;
    logic [LSIZE-1:0] req_len_q, req_len_d;
    logic             req_valid_q, req_valid_d;
    logic             burst_done_q, burst_done_d;
    logic             tail_done_q, tail_done_d;
    logic             busy_q, busy_d;

    logic             fsync_acc;
    logic             do_restart;
    logic [ASIZE-1:0] restart_addr;

    assign fsync_acc = fsync & enable;

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        addr_d       = addr_q;
        pend_addr_d  = pend_addr_q;
        pend_d       = pend_q;
        is_tail_d    = is_tail_q;
        cnt_d        = cnt_q;
        req_addr_d   = req_addr_q;
        req_len_d    = req_len_q;
        burst_done_d = 1'b0;
        tail_done_d  = 1'b0;
        do_restart   = 1'b0;
        restart_addr = base_addr;

        unique case (state_q)
            S_IDLE: begin
                do_restart = fsync_acc;
            end
            S_SETTLE: begin
                if (fsync_acc) begin
                    do_restart = 1'b1;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = S_DECIDE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_DECIDE: begin
                if (fsync_acc) begin
                    do_restart = 1'b1;
                end else begin
                    is_tail_d  = tail_status;
                    req_len_d  = tail_status ? tail_len : NOR_LEN;
                    req_addr_d = addr_q;
                    state_d    = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (fsync_acc) begin
                    do_restart = 1'b1;
                end else if (32'(fifo_space) >= 32'(req_len_q)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A restart here must wait for the burst to drain, so only remember it.
                if (fsync_acc) begin
                    pend_d      = 1'b1;
                    pend_addr_d = base_addr;
                end
                if (req_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (fsync_acc) begin
                    pend_d      = 1'b1;
                    pend_addr_d = base_addr;
                end
                if (rd_done) begin
                    if (pend_q || fsync_acc) begin
                        do_restart   = 1'b1;
                        restart_addr = fsync_acc ? base_addr : pend_addr_q;
                    end else begin
                        state_d      = S_DONE;
                        burst_done_d = ~is_tail_q;
                        tail_done_d  = is_tail_q;
                    end
                end
            end
            S_DONE: begin
                addr_d = addr_q + ASIZE'(req_len_q) * BEAT_BYTES;
                cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (fsync_acc) begin
                    do_restart = 1'b1;
                end else if (is_tail_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_SETTLE;
                    settle_d = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_restart) begin
            state_d  = S_SETTLE;
            settle_d = 4'd0;
            addr_d   = restart_addr;
            cnt_d    = 16'd0;
            pend_d   = 1'b0;
        end

        req_valid_d = (state_d == S_REQ);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            settle_q     <= 4'd0;
            addr_q       <= '0;
            pend_addr_q  <= '0;
            pend_q       <= 1'b0;
            is_tail_q    <= 1'b0;
            cnt_q        <= 16'd0;
            req_addr_q   <= '0;
            req_len_q    <= '0;
            req_valid_q  <= 1'b0;
            burst_done_q <= 1'b0;
            tail_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            addr_q       <= addr_d;
            pend_addr_q  <= pend_addr_d;
            pend_q       <= pend_d;
            is_tail_q    <= is_tail_d;
            cnt_q        <= cnt_d;
            req_addr_q   <= req_addr_d;
            req_len_q    <= req_len_d;
            req_valid_q  <= req_valid_d;
            burst_done_q <= burst_done_d;
            tail_done_q  <= tail_done_d;
            busy_q       <= busy_d;
        end
    end

    assign req_valid  = req_valid_q;
    assign req_addr   = req_addr_q;
    assign req_len    = req_len_q;
    assign burst_done = burst_done_q;
    assign tail_done  = tail_done_q;
    assign busy       = busy_q;
    assign burst_cnt  = cnt_q;

endmodule

// File: tb/tb_read_burst_scheduler.sv
// Directed bench for read_burst_scheduler; expected requests and done pulses go into queues checked by a monitor.
module tb_read_burst_scheduler;

    localparam int NOR = 16;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        fsync = 1'b0;
    logic [31:0] base_addr = '0;
    logic        tail_status = 1'b0;
    logic [8:0]  tail_len = 9'd5;
    logic [15:0] fifo_space = 16'hFFFF;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic [8:0]  req_len;
    logic        rd_done = 1'b0;
    logic        burst_done;
    logic        tail_done;
    logic        busy;
    logic [15:0] burst_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [31:0] exp_addr_q[$];
    logic [8:0]  exp_len_q[$];
    int          exp_done_q[$];

    read_burst_scheduler #(
        .NOR_BURST_LEN(NOR), .LSIZE(9), .ASIZE(32), .AXI_DSIZE(256), .SETTLE(4)
    ) dut (
        .clock(clock), .rst_n(rst_n), .enable(enable), .fsync(fsync),
        .base_addr(base_addr), .tail_status(tail_status), .tail_len(tail_len),
        .fifo_space(fifo_space), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .rd_done(rd_done),
        .burst_done(burst_done), .tail_done(tail_done), .busy(busy),
        .burst_cnt(burst_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: compares every handshake and done pulse against the queued expectations.
    int          mon_kind;
    logic [31:0] mon_addr;
    logic [8:0]  mon_len;
    always @(negedge clock) begin
        if (req_valid && req_ready) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_req", {32'd0, req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_addr = exp_addr_q.pop_front();
                mon_len  = exp_len_q.pop_front();
                check("req_addr", {32'd0, req_addr}, {32'd0, mon_addr});
                check("req_len", {55'd0, req_len}, {55'd0, mon_len});
            end
        end
        if (burst_done || tail_done) begin
            mon_kind = burst_done ? (tail_done ? 3 : 1) : 2;
            if (exp_done_q.size() == 0) check("unexpected_done", 64'(mon_kind), 64'd0);
            else check("done_kind", 64'(mon_kind), 64'(exp_done_q.pop_front()));
        end
    end

    task automatic pulse_fsync(input logic [31:0] base);
        base_addr = base;
        fsync     = 1'b1;
        tick();
        fsync     = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!req_valid && n < 300) begin
            tick();
            n++;
        end
        if (!req_valid) check("req_timeout", 64'd0, 64'd1);
    endtask

    // kind: 1 burst_done expected, 2 tail_done expected, 0 no pulse expected.
    task automatic serve(input logic [31:0] addr, input logic [8:0] len, input int rdy_wait,
                         input int done_wait, input int kind, input bit mid_fsync,
                         input logic [31:0] mid_base);
        exp_addr_q.push_back(addr);
        exp_len_q.push_back(len);
        wait_req();
        for (int i = 0; i < rdy_wait; i++) begin
            check("hold_valid", {63'd0, req_valid}, 64'd1);
            check("hold_addr", {32'd0, req_addr}, {32'd0, addr});
            check("hold_len", {55'd0, req_len}, {55'd0, len});
            tick();
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("valid_drop", {63'd0, req_valid}, 64'd0);
        if (mid_fsync) pulse_fsync(mid_base);
        tick(done_wait);
        rd_done = 1'b1;
        if (kind != 0) exp_done_q.push_back(kind);
        tick();
        rd_done = 1'b0;
    endtask

    initial begin
        tick(3);
        check("rst_req_valid", {63'd0, req_valid}, 64'd0);
        check("rst_req_addr", {32'd0, req_addr}, 64'd0);
        check("rst_req_len", {55'd0, req_len}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_burst_cnt", {48'd0, burst_cnt}, 64'd0);
        check("rst_done", {62'd0, burst_done, tail_done}, 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Full frame: two normal bursts then a 5-beat tail; first request 7 cycles after fsync.
        tail_len = 9'd5;
        pulse_fsync(32'h1000);
        check("busy_after_fsync", {63'd0, busy}, 64'd1);
        tick(5);
        check("valid_before_t7", {63'd0, req_valid}, 64'd0);
        tick();
        check("valid_at_t7", {63'd0, req_valid}, 64'd1);
        serve(32'h1000, 9'd16, 10, 3, 1, 1'b0, 32'h0);
        tick();
        check("cnt_after_b1", {48'd0, burst_cnt}, 64'd1);
        serve(32'h1200, 9'd16, 0, 2, 1, 1'b0, 32'h0);
        tail_status = 1'b1;
        serve(32'h1400, 9'd5, 0, 1, 2, 1'b0, 32'h0);
        check("busy_at_tail_done", {63'd0, busy}, 64'd1);
        tick();
        check("busy_after_tail", {63'd0, busy}, 64'd0);
        check("cnt_frame", {48'd0, burst_cnt}, 64'd3);
        tail_status = 1'b0;
        tick(3);

        // FIFO space gating, then restart while the second burst is in flight.
        fifo_space = 16'd10;
        pulse_fsync(32'h2000);
        tick(20);
        check("no_valid_low_space", {63'd0, req_valid}, 64'd0);
        fifo_space = 16'd16;
        check("no_valid_same_cycle", {63'd0, req_valid}, 64'd0);
        tick();
        check("valid_after_space", {63'd0, req_valid}, 64'd1);
        serve(32'h2000, 9'd16, 0, 2, 1, 1'b0, 32'h0);
        fifo_space = 16'hFFFF;
        serve(32'h2200, 9'd16, 0, 2, 0, 1'b1, 32'h3000);
        check("cnt_restart", {48'd0, burst_cnt}, 64'd0);
        tail_status = 1'b1;
        serve(32'h3000, 9'd5, 0, 1, 2, 1'b0, 32'h0);
        tick();
        check("busy_end_restart", {63'd0, busy}, 64'd0);
        check("cnt_after_restart", {48'd0, burst_cnt}, 64'd1);
        tick(3);

        // Tail at the very first decision: one 3-beat request, tail_done only.
        tail_len = 9'd3;
        pulse_fsync(32'h4000);
        serve(32'h4000, 9'd3, 0, 2, 2, 1'b0, 32'h0);
        tick();
        check("busy_single_tail", {63'd0, busy}, 64'd0);
        check("cnt_single_tail", {48'd0, burst_cnt}, 64'd1);
        tail_status = 1'b0;
        tick(3);

        // Reset while waiting for rd_done; late rd_done must be dropped.
        pulse_fsync(32'h5000);
        exp_addr_q.push_back(32'h5000);
        exp_len_q.push_back(9'd16);
        wait_req();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        tick(2);
        rst_n = 1'b0;
        tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        rst_n   = 1'b1;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        tick(2);
        check("rr_req_valid", {63'd0, req_valid}, 64'd0);
        check("rr_req_addr", {32'd0, req_addr}, 64'd0);
        check("rr_req_len", {55'd0, req_len}, 64'd0);
        check("rr_busy", {63'd0, busy}, 64'd0);
        check("rr_burst_cnt", {48'd0, burst_cnt}, 64'd0);

        // fsync ignored while disabled.
        enable = 1'b0;
        pulse_fsync(32'h6000);
        tick(12);
        check("dis_busy", {63'd0, busy}, 64'd0);
        check("dis_req_valid", {63'd0, req_valid}, 64'd0);
        enable = 1'b1;
        tick(2);

        check("req_queue_empty", 64'(exp_addr_q.size()), 64'd0);
        check("done_queue_empty", 64'(exp_done_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
